inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues word-aligned reads, holds one fetched
// instruction for decode, and absorbs redirects that race in-flight reads.
package CorePack;
  typedef logic [31:0] inst_t;
endpackage

module inst_fetch #(
  parameter int unsigned        ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  inst_valid,
  output CorePack::inst_t       inst,
  output logic [ADDR_W-1:0]     inst_pc,
  input  logic                  inst_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc
);

  // state | meaning
  // IDLE  | post-reset bubble, no request
  // REQ   | read outstanding at pc_q
  // VALID | instruction held for decode
  typedef enum logic [1:0] {IDLE, REQ, VALID} state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam CorePack::inst_t   NOP        = 32'h0000_0013;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     pending_pc_q, pending_pc_d;
  logic                  kill_q, kill_d;
  CorePack::inst_t       inst_q, inst_d;
  logic [ADDR_W-1:0]     inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0]     redir_aligned;

  assign redir_aligned = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC & ALIGN_MASK;
      pending_pc_q <= '0;
      kill_q       <= 1'b0;
      inst_q       <= NOP;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redir_aligned;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // a same-cycle redirect is newer than any recorded one
            pc_d   = redir_aligned;
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_d   = pending_pc_q;
            kill_d = 1'b0;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = VALID;
          end
        end else if (redirect_valid) begin
          // address must stay put until the outstanding read completes
          pending_pc_d = redir_aligned;
          kill_d       = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_d    = redir_aligned;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = inst_pc_q + ADDR_W'(4);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      REQ:     imem_req   = 1'b1;
      VALID:   inst_valid = 1'b1;
      default: ;
    endcase
    imem_addr = pc_q;
    inst      = inst_q;
    inst_pc   = inst_pc_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed fetch, stall, redirect, wrap and reset scenarios
// against a reference fetch model and hand-computed expectations.
module tb_inst_fetch;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic          auto_ack = 1'b0;
  logic          ack_force = 1'b0;
  logic [31:0]   rdata_xor = '0;
  logic          chk_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // memory: zero-wait when auto_ack, data = word index of the address
  assign imem_ack   = ack_force | (auto_ack & imem_req);
  assign imem_rdata = imem_addr[33:2] ^ rdata_xor;

  inst_fetch #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic cmp(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: "fetching" means a read is outstanding for m_want; a redirect
  // seen while fetching retargets the next read; returned data is only kept
  // when nothing retargeted it.
  int            m_phase;   // 0 bubble, 1 fetching, 2 holding
  logic [AW-1:0] m_want, m_retarget, m_hold_pc;
  bit            m_stale;
  logic [31:0]   m_hold;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_want = '0; m_stale = 0; m_retarget = '0;
      m_hold = 32'h13; m_hold_pc = '0;
    end else if (m_phase == 0) begin
      if (redirect_valid) m_want = {redirect_pc[AW-1:2], 2'b00};
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_ack && (m_stale || redirect_valid)) begin
        m_want  = redirect_valid ? {redirect_pc[AW-1:2], 2'b00} : m_retarget;
        m_stale = 0;
      end else if (imem_ack) begin
        m_hold = imem_rdata; m_hold_pc = m_want; m_phase = 2;
      end else if (redirect_valid) begin
        m_retarget = {redirect_pc[AW-1:2], 2'b00};
        m_stale = 1;
      end
    end else begin
      if (redirect_valid) begin
        m_want = {redirect_pc[AW-1:2], 2'b00}; m_phase = 1;
      end else if (inst_ready) begin
        m_want = m_hold_pc + 64'd4; m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_req", AW'(imem_req), AW'(m_phase == 1));
      cmp("m_valid", AW'(inst_valid), AW'(m_phase == 2));
      if (m_phase == 1) cmp("m_addr", imem_addr, m_want);
      if (m_phase == 2) begin
        cmp("m_inst", AW'(inst), AW'(m_hold));
        cmp("m_inst_pc", inst_pc, m_hold_pc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [AW-1:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
  endtask

  initial begin
    step(2);
    chk_on = 1'b1;
    cmp("rst_req", AW'(imem_req), 0);
    cmp("rst_valid", AW'(inst_valid), 0);
    cmp("rst_inst", AW'(inst), 64'h13);
    cmp("rst_inst_pc", inst_pc, 0);

    // reset release, zero-wait memory
    rst = 1'b0; auto_ack = 1'b1;
    step(1);
    cmp("first_addr", imem_addr, 64'h0);
    cmp("first_req", AW'(imem_req), 1);
    step(1);
    cmp("first_valid", AW'(inst_valid), 1);
    cmp("first_inst", AW'(inst), 0);
    cmp("first_pc", inst_pc, 0);
    inst_ready = 1'b1;
    step(1);
    cmp("next_addr", imem_addr, 64'h4);
    inst_ready = 1'b0;
    step(1);
    cmp("second_inst", AW'(inst), 64'h1);

    // memory stall at 0x8
    auto_ack = 1'b0; inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp("stall_addr", imem_addr, 64'h8);
      cmp("stall_valid", AW'(inst_valid), 0);
      step(1);
    end
    auto_ack = 1'b1;
    step(1);

    // decode back-pressure
    for (int i = 0; i < 3; i++) begin
      step(1);
      cmp("hold_inst", AW'(inst), 64'h2);
      cmp("hold_pc", inst_pc, 64'h8);
    end
    inst_ready = 1'b1;
    step(1);
    cmp("after_hold_addr", imem_addr, 64'hC);
    inst_ready = 1'b0;
    step(1);

    // redirect during outstanding read at 0x10
    inst_ready = 1'b1; auto_ack = 1'b0;
    step(1);
    inst_ready = 1'b0; redir(64'h100);
    step(1);
    cmp("kill_addr_stable", imem_addr, 64'h10);
    redirect_valid = 1'b0;
    step(1);
    ack_force = 1'b1;
    step(1);
    cmp("killed_valid", AW'(inst_valid), 0);
    cmp("killed_next_addr", imem_addr, 64'h100);
    ack_force = 1'b0; auto_ack = 1'b1;
    step(1);
    cmp("redir_inst_pc", inst_pc, 64'h100);
    cmp("redir_inst", AW'(inst), 64'h40);

    // redirect beats ready in VALID; misaligned target
    redir(64'h40);
    step(1);
    redirect_valid = 1'b0;
    step(1);
    cmp("at40_pc", inst_pc, 64'h40);
    redir(64'h200); inst_ready = 1'b1;
    step(1);
    cmp("redir_vs_ready", imem_addr, 64'h200);
    cmp("redir_drop_valid", AW'(inst_valid), 0);
    redirect_valid = 1'b0; inst_ready = 1'b0;
    step(1);
    redir(64'h203);
    step(1);
    cmp("misaligned_redir", imem_addr, 64'h200);
    redirect_valid = 1'b0;
    step(1);
    cmp("inst_200", AW'(inst), 64'h80);

    // same-cycle redirect beats pending; last pending wins
    inst_ready = 1'b1; auto_ack = 1'b0;
    step(1);
    inst_ready = 1'b0; redir(64'h300);
    step(1);
    redir(64'h310);
    step(1);
    redir(64'h320); ack_force = 1'b1;
    step(1);
    cmp("same_cycle_wins", imem_addr, 64'h320);
    redirect_valid = 1'b0; ack_force = 1'b0;
    redir(64'h400);
    step(1);
    redir(64'h410);
    step(1);
    redirect_valid = 1'b0; ack_force = 1'b1;
    step(1);
    cmp("last_pending_wins", imem_addr, 64'h410);
    ack_force = 1'b0; auto_ack = 1'b1;
    step(1);
    cmp("inst_410", AW'(inst), 64'h104);

    // ack outside REQ ignored
    auto_ack = 1'b0; ack_force = 1'b1; rdata_xor = 32'hDEAD_0000;
    step(2);
    cmp("stray_ack_inst", AW'(inst), 64'h104);
    cmp("stray_ack_valid", AW'(inst_valid), 1);
    ack_force = 1'b0; rdata_xor = '0;

    // wrap at top of address space
    auto_ack = 1'b1; redir(64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    redirect_valid = 1'b0;
    step(1);
    cmp("top_inst", AW'(inst), 64'hFFFF_FFFF);
    cmp("top_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    step(1);
    cmp("wrap_addr", imem_addr, 64'h0);
    inst_ready = 1'b0; auto_ack = 1'b0;

    // redirect taken in IDLE
    rst = 1'b1;
    step(1);
    cmp("rst2_valid", AW'(inst_valid), 0);
    cmp("rst2_inst", AW'(inst), 64'h13);
    rst = 1'b0; redir(64'h500);
    step(1);
    cmp("idle_redir", imem_addr, 64'h500);
    redirect_valid = 1'b0;

    // reset mid-REQ with acks during and right after
    rst = 1'b1; ack_force = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    cmp("post_rst_addr", imem_addr, 64'h0);
    cmp("post_rst_valid", AW'(inst_valid), 0);
    ack_force = 1'b0;
    step(1);
    cmp("post_rst_wait", AW'(inst_valid), 0);
    ack_force = 1'b1;
    step(1);
    cmp("post_rst_fetch", AW'(inst_valid), 1);
    cmp("post_rst_pc", inst_pc, 64'h0);
    ack_force = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
